// File: rtl/tds_chk_pkg.sv
// Shared types and constants for the multi-channel TDS link checker.
package tds_chk_pkg;

  // Width of the per-channel sync progress counter (holds up to 1023).
  localparam int SYN_W = 10;

  // Default frame header expected at the top of every TDS frame.
  localparam logic [5:0] TDS_HEADER_DEF = 6'b101010;

  // Per-channel link state; encoding 2'd3 is unused and recovers to HUNT.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LINKED = 2'd2
  } tds_state_e;

endpackage

// File: rtl/tds_link_chan.sv
// Single TDS channel: hunt/sync/linked FSM, error and window counters,
// and the good-frame forwarding register.
module tds_link_chan
  import tds_chk_pkg::*;
#(
  parameter int              DATA_W = 30,
  parameter int              HDR_W  = 6,
  parameter logic [HDR_W-1:0] HEADER = TDS_HEADER_DEF,
  parameter int              CNT_W  = 8,
  parameter int              SYNC_N = 16,
  parameter int              LOSS_N = 4,
  parameter int              WIN    = 64,
  parameter int              ERR_W  = 16
) (
  input  logic              clk160,
  input  logic              reset,
  input  logic [DATA_W-1:0] frame_in,
  input  logic              frame_valid,
  input  logic              clear_err,
  output logic              linked,
  output logic              err_hit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [1:0]        state,
  output logic [SYN_W-1:0]  syn_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int WE_W = $clog2(LOSS_N + 1);
  localparam int WF_W = $clog2(WIN);

  tds_state_e        state_q, state_d;
  logic [SYN_W-1:0]  syn_cnt_q, syn_cnt_d;
  logic [CNT_W-1:0]  exp_q, exp_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WE_W-1:0]   win_err_q, win_err_d;
  logic [WF_W-1:0]   win_frm_q, win_frm_d;
  logic              linked_q, linked_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  logic              hdr_ok_s, cnt_ok_s, good_s, wrap_s, fwd_s, err_hit_s;
  logic [CNT_W-1:0]  rx_cnt_s;
  logic [WE_W-1:0]   win_err_base_s, win_err_inc_s;

  // Frame checks, FSM next state and window/sync counter updates.
  always_comb begin
    rx_cnt_s       = frame_in[CNT_W-1:0];
    hdr_ok_s       = (frame_in[DATA_W-1 -: HDR_W] == HEADER);
    cnt_ok_s       = (rx_cnt_s == exp_q);
    good_s         = hdr_ok_s && cnt_ok_s;
    wrap_s         = (win_frm_q == WF_W'(WIN - 1));
    // The window restart drops old errors before this frame is counted.
    win_err_base_s = wrap_s ? {WE_W{1'b0}} : win_err_q;
    win_err_inc_s  = win_err_base_s + (good_s ? {WE_W{1'b0}} : WE_W'(1));

    state_d   = state_q;
    syn_cnt_d = syn_cnt_q;
    exp_d     = exp_q;
    win_err_d = win_err_q;
    win_frm_d = win_frm_q;
    linked_d  = linked_q;
    fwd_s     = 1'b0;
    err_hit_s = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (frame_valid) begin
          exp_d = rx_cnt_s + CNT_W'(1);
          if (hdr_ok_s) begin
            state_d   = ST_SYNC;
            syn_cnt_d = SYN_W'(1);
          end else begin
            syn_cnt_d = {SYN_W{1'b0}};
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_SYNC: begin
        if (frame_valid) begin
          exp_d = rx_cnt_s + CNT_W'(1);
          if (good_s) begin
            syn_cnt_d = syn_cnt_q + SYN_W'(1);
            if ((syn_cnt_q + SYN_W'(1)) == SYN_W'(SYNC_N)) begin
              state_d   = ST_LINKED;
              linked_d  = 1'b1;
              win_err_d = {WE_W{1'b0}};
              win_frm_d = {WF_W{1'b0}};
            end else begin
              state_d = ST_SYNC;
            end
          end else begin
            state_d   = ST_HUNT;
            syn_cnt_d = {SYN_W{1'b0}};
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LINKED: begin
        if (frame_valid) begin
          exp_d     = rx_cnt_s + CNT_W'(1);
          win_frm_d = wrap_s ? {WF_W{1'b0}} : (win_frm_q + WF_W'(1));
          if (good_s) begin
            fwd_s     = 1'b1;
            win_err_d = win_err_base_s;
          end else begin
            err_hit_s = 1'b1;
            if (win_err_inc_s == WE_W'(LOSS_N)) begin
              state_d   = ST_HUNT;
              linked_d  = 1'b0;
              syn_cnt_d = {SYN_W{1'b0}};
              win_err_d = {WE_W{1'b0}};
              win_frm_d = {WF_W{1'b0}};
            end else begin
              win_err_d = win_err_inc_s;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = ST_HUNT;
        syn_cnt_d = {SYN_W{1'b0}};
        linked_d  = 1'b0;
        win_err_d = {WE_W{1'b0}};
        win_frm_d = {WF_W{1'b0}};
      end
    endcase
  end

  // Saturating error counter; a clear coinciding with an error leaves one count.
  always_comb begin
    if (clear_err) begin
      err_cnt_d = err_hit_s ? ERR_W'(1) : {ERR_W{1'b0}};
    end else if (err_hit_s && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Forward good linked frames; data_out holds the last forwarded frame.
  always_comb begin
    data_valid_d = fwd_s;
    if (fwd_s) begin
      data_out_d = frame_in;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      syn_cnt_q    <= {SYN_W{1'b0}};
      exp_q        <= {CNT_W{1'b0}};
      err_cnt_q    <= {ERR_W{1'b0}};
      win_err_q    <= {WE_W{1'b0}};
      win_frm_q    <= {WF_W{1'b0}};
      linked_q     <= 1'b0;
      data_out_q   <= {DATA_W{1'b0}};
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      syn_cnt_q    <= syn_cnt_d;
      exp_q        <= exp_d;
      err_cnt_q    <= err_cnt_d;
      win_err_q    <= win_err_d;
      win_frm_q    <= win_frm_d;
      linked_q     <= linked_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign linked     = linked_q;
  assign err_hit    = err_hit_s;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign state      = state_q;
  assign syn_cnt    = syn_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: rtl/tds_link_checker_mc.sv
// Multi-channel TDS link checker: per-channel checkers plus aggregate
// status and a registered channel-select debug readout.
module tds_link_checker_mc
  import tds_chk_pkg::*;
#(
  parameter int               NUM_CH = 4,
  parameter int               DATA_W = 30,
  parameter int               HDR_W  = 6,
  parameter logic [HDR_W-1:0] HEADER = TDS_HEADER_DEF,
  parameter int               CNT_W  = 8,
  parameter int               SYNC_N = 16,
  parameter int               LOSS_N = 4,
  parameter int               WIN    = 64,
  parameter int               ERR_W  = 16,
  localparam int              SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk160,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] frame_in,
  input  logic [NUM_CH-1:0]        frame_valid,
  input  logic                     clear_err,
  input  logic [SEL_W-1:0]         sel_ch,
  output logic [NUM_CH-1:0]        linked,
  output logic                     all_linked,
  output logic                     err_sticky,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        data_valid,
  output logic [1:0]               rd_state,
  output logic [SYN_W-1:0]         rd_syn_cnt,
  output logic [ERR_W-1:0]         rd_err_cnt
);

  logic [NUM_CH-1:0] err_hit_s;
  logic [1:0]        chan_state_s [NUM_CH];
  logic [SYN_W-1:0]  chan_syn_s   [NUM_CH];
  logic [ERR_W-1:0]  chan_err_s   [NUM_CH];

  logic              all_linked_q, all_linked_d;
  logic              err_sticky_q, err_sticky_d;
  logic [1:0]        rd_state_q, rd_state_d;
  logic [SYN_W-1:0]  rd_syn_cnt_q, rd_syn_cnt_d;
  logic [ERR_W-1:0]  rd_err_cnt_q, rd_err_cnt_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    tds_link_chan #(
      .DATA_W (DATA_W),
      .HDR_W  (HDR_W),
      .HEADER (HEADER),
      .CNT_W  (CNT_W),
      .SYNC_N (SYNC_N),
      .LOSS_N (LOSS_N),
      .WIN    (WIN),
      .ERR_W  (ERR_W)
    ) u_chan (
      .clk160      (clk160),
      .reset       (reset),
      .frame_in    (frame_in[g*DATA_W +: DATA_W]),
      .frame_valid (frame_valid[g]),
      .clear_err   (clear_err),
      .linked      (linked[g]),
      .err_hit     (err_hit_s[g]),
      .data_out    (data_out[g*DATA_W +: DATA_W]),
      .data_valid  (data_valid[g]),
      .state       (chan_state_s[g]),
      .syn_cnt     (chan_syn_s[g]),
      .err_cnt     (chan_err_s[g])
    );
  end

  // Aggregate link flag and sticky error flag; clear loses to a same-cycle error.
  always_comb begin
    all_linked_d = &linked;
    if (clear_err) begin
      err_sticky_d = |err_hit_s;
    end else begin
      err_sticky_d = err_sticky_q | (|err_hit_s);
    end
  end

  // Debug readout mux; a channel index beyond NUM_CH reads as zero.
  always_comb begin
    if (int'(sel_ch) < NUM_CH) begin
      rd_state_d   = chan_state_s[sel_ch];
      rd_syn_cnt_d = chan_syn_s[sel_ch];
      rd_err_cnt_d = chan_err_s[sel_ch];
    end else begin
      rd_state_d   = 2'b00;
      rd_syn_cnt_d = {SYN_W{1'b0}};
      rd_err_cnt_d = {ERR_W{1'b0}};
    end
  end

  // Aggregate and readout registers.
  always_ff @(posedge clk160 or posedge reset) begin
    if (reset) begin
      all_linked_q <= 1'b0;
      err_sticky_q <= 1'b0;
      rd_state_q   <= 2'b00;
      rd_syn_cnt_q <= {SYN_W{1'b0}};
      rd_err_cnt_q <= {ERR_W{1'b0}};
    end else begin
      all_linked_q <= all_linked_d;
      err_sticky_q <= err_sticky_d;
      rd_state_q   <= rd_state_d;
      rd_syn_cnt_q <= rd_syn_cnt_d;
      rd_err_cnt_q <= rd_err_cnt_d;
    end
  end

  assign all_linked = all_linked_q;
  assign err_sticky = err_sticky_q;
  assign rd_state   = rd_state_q;
  assign rd_syn_cnt = rd_syn_cnt_q;
  assign rd_err_cnt = rd_err_cnt_q;

endmodule

// File: tb/tb_tds_link_checker_mc.sv
// Directed self-checking bench for tds_link_checker_mc.
module tb_tds_link_checker_mc;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 30;
  localparam logic [5:0] HDR_OK  = 6'b101010;
  localparam logic [5:0] HDR_BAD = 6'b101011;

  logic                     clk160 = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] frame_in;
  logic [NUM_CH-1:0]        frame_valid;
  logic                     clear_err;
  logic [1:0]               sel_ch;
  logic [NUM_CH-1:0]        linked;
  logic                     all_linked;
  logic                     err_sticky;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        data_valid;
  logic [1:0]               rd_state;
  logic [9:0]               rd_syn_cnt;
  logic [15:0]              rd_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  tds_link_checker_mc dut (
    .clk160      (clk160),
    .reset       (reset),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .clear_err   (clear_err),
    .sel_ch      (sel_ch),
    .linked      (linked),
    .all_linked  (all_linked),
    .err_sticky  (err_sticky),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .rd_state    (rd_state),
    .rd_syn_cnt  (rd_syn_cnt),
    .rd_err_cnt  (rd_err_cnt)
  );

  always #5 clk160 = ~clk160;

  function automatic logic [29:0] mkf(input logic [5:0] h, input logic [7:0] c);
    return {h, 16'hA5C3, c};
  endfunction

  // One valid frame on one channel; returns 1 time unit after the capturing edge.
  task automatic send1(input int ch, input logic [5:0] h, input logic [7:0] c);
    frame_in[ch*DATA_W +: DATA_W] = mkf(h, c);
    frame_valid = 4'b0000;
    frame_valid[ch] = 1'b1;
    @(posedge clk160); #1;
    frame_valid = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk160); #1; end
  endtask

  task automatic link_ch(input int ch, input logic [7:0] start);
    for (int i = 0; i < 16; i++) send1(ch, HDR_OK, start + 8'(i));
  endtask

  task automatic test_reset;
    n_cmp++; if (linked !== 4'b0000) begin $display("FAIL rst_linked actual=%b expected=%b", linked, 4'b0000); n_bad++; end
    n_cmp++; if (all_linked !== 1'b0) begin $display("FAIL rst_all_linked actual=%b expected=0", all_linked); n_bad++; end
    n_cmp++; if (err_sticky !== 1'b0) begin $display("FAIL rst_err_sticky actual=%b expected=0", err_sticky); n_bad++; end
    n_cmp++; if (data_valid !== 4'b0000) begin $display("FAIL rst_data_valid actual=%b expected=0000", data_valid); n_bad++; end
    n_cmp++; if (data_out !== 120'd0) begin $display("FAIL rst_data_out actual=%h expected=0", data_out); n_bad++; end
    n_cmp++; if (rd_state !== 2'd0) begin $display("FAIL rst_rd_state actual=%0d expected=0", rd_state); n_bad++; end
    n_cmp++; if (rd_syn_cnt !== 10'd0) begin $display("FAIL rst_rd_syn_cnt actual=%0d expected=0", rd_syn_cnt); n_bad++; end
    n_cmp++; if (rd_err_cnt !== 16'd0) begin $display("FAIL rst_rd_err_cnt actual=%0d expected=0", rd_err_cnt); n_bad++; end
  endtask

  task automatic test_sync;
    sel_ch = 2'd0;
    for (int i = 0; i < 15; i++) send1(0, HDR_OK, 8'(i));
    n_cmp++; if (linked[0] !== 1'b0) begin $display("FAIL sync_early_link actual=%b expected=0", linked[0]); n_bad++; end
    send1(0, HDR_OK, 8'd15);
    n_cmp++; if (linked[0] !== 1'b1) begin $display("FAIL sync_link_rise actual=%b expected=1", linked[0]); n_bad++; end
    n_cmp++; if (data_valid[0] !== 1'b0) begin $display("FAIL sync_no_fwd16 actual=%b expected=0", data_valid[0]); n_bad++; end
    n_cmp++; if (rd_syn_cnt !== 10'd15) begin $display("FAIL sync_rd_lag actual=%0d expected=15", rd_syn_cnt); n_bad++; end
    idle(1);
    n_cmp++; if (rd_syn_cnt !== 10'd16) begin $display("FAIL sync_rd_syn actual=%0d expected=16", rd_syn_cnt); n_bad++; end
    n_cmp++; if (rd_state !== 2'd2) begin $display("FAIL sync_rd_state actual=%0d expected=2", rd_state); n_bad++; end
    n_cmp++; if (all_linked !== 1'b0) begin $display("FAIL sync_all_linked actual=%b expected=0", all_linked); n_bad++; end
    send1(0, HDR_OK, 8'd16);
    n_cmp++; if (data_valid[0] !== 1'b1) begin $display("FAIL sync_fwd17 actual=%b expected=1", data_valid[0]); n_bad++; end
    n_cmp++; if (data_out[29:0] !== mkf(HDR_OK, 8'd16)) begin $display("FAIL sync_data17 actual=%h expected=%h", data_out[29:0], mkf(HDR_OK, 8'd16)); n_bad++; end
  endtask

  task automatic test_slip;
    for (int c = 17; c <= 21; c++) send1(0, HDR_OK, 8'(c));
    send1(0, HDR_OK, 8'd25);
    n_cmp++; if (data_valid[0] !== 1'b0) begin $display("FAIL slip_no_fwd actual=%b expected=0", data_valid[0]); n_bad++; end
    n_cmp++; if (err_sticky !== 1'b1) begin $display("FAIL slip_sticky actual=%b expected=1", err_sticky); n_bad++; end
    send1(0, HDR_OK, 8'd26);
    n_cmp++; if (data_valid[0] !== 1'b1) begin $display("FAIL slip_fwd26 actual=%b expected=1", data_valid[0]); n_bad++; end
    n_cmp++; if (data_out[29:0] !== mkf(HDR_OK, 8'd26)) begin $display("FAIL slip_data26 actual=%h expected=%h", data_out[29:0], mkf(HDR_OK, 8'd26)); n_bad++; end
    n_cmp++; if (linked[0] !== 1'b1) begin $display("FAIL slip_linked actual=%b expected=1", linked[0]); n_bad++; end
    idle(1);
    n_cmp++; if (rd_err_cnt !== 16'd1) begin $display("FAIL slip_err_cnt actual=%0d expected=1", rd_err_cnt); n_bad++; end
  endtask

  task automatic test_clear_err;
    clear_err = 1'b1;
    send1(0, HDR_BAD, 8'd27);
    clear_err = 1'b0;
    n_cmp++; if (err_sticky !== 1'b1) begin $display("FAIL clr_hit_sticky actual=%b expected=1", err_sticky); n_bad++; end
    idle(1);
    n_cmp++; if (rd_err_cnt !== 16'd1) begin $display("FAIL clr_hit_err_cnt actual=%0d expected=1", rd_err_cnt); n_bad++; end
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    n_cmp++; if (err_sticky !== 1'b0) begin $display("FAIL clr_only_sticky actual=%b expected=0", err_sticky); n_bad++; end
    idle(1);
    n_cmp++; if (rd_err_cnt !== 16'd0) begin $display("FAIL clr_only_err_cnt actual=%0d expected=0", rd_err_cnt); n_bad++; end
  endtask

  task automatic test_loss;
    sel_ch = 2'd1;
    link_ch(1, 8'd0);
    for (int c = 16; c <= 18; c++) send1(1, HDR_BAD, 8'(c));
    n_cmp++; if (linked[1] !== 1'b1) begin $display("FAIL loss_3err_linked actual=%b expected=1", linked[1]); n_bad++; end
    send1(1, HDR_BAD, 8'd19);
    n_cmp++; if (linked[1] !== 1'b0) begin $display("FAIL loss_4err_linked actual=%b expected=0", linked[1]); n_bad++; end
    idle(1);
    n_cmp++; if (rd_state !== 2'd0) begin $display("FAIL loss_rd_state actual=%0d expected=0", rd_state); n_bad++; end
    n_cmp++; if (rd_err_cnt !== 16'd4) begin $display("FAIL loss_err_cnt actual=%0d expected=4", rd_err_cnt); n_bad++; end
    n_cmp++; if (rd_syn_cnt !== 10'd0) begin $display("FAIL loss_syn_cnt actual=%0d expected=0", rd_syn_cnt); n_bad++; end
    for (int i = 0; i < 15; i++) send1(1, HDR_OK, 8'(20 + i));
    n_cmp++; if (linked[1] !== 1'b0) begin $display("FAIL loss_resync15 actual=%b expected=0", linked[1]); n_bad++; end
    send1(1, HDR_OK, 8'd35);
    n_cmp++; if (linked[1] !== 1'b1) begin $display("FAIL loss_resync16 actual=%b expected=1", linked[1]); n_bad++; end
  endtask

  task automatic test_window;
    sel_ch = 2'd2;
    link_ch(2, 8'd0);
    for (int c = 16; c <= 18; c++) send1(2, HDR_BAD, 8'(c));
    for (int c = 19; c <= 82; c++) send1(2, HDR_OK, 8'(c));
    for (int c = 83; c <= 85; c++) send1(2, HDR_BAD, 8'(c));
    n_cmp++; if (linked[2] !== 1'b1) begin $display("FAIL win_linked actual=%b expected=1", linked[2]); n_bad++; end
    idle(1);
    n_cmp++; if (rd_err_cnt !== 16'd6) begin $display("FAIL win_err_cnt actual=%0d expected=6", rd_err_cnt); n_bad++; end
    n_cmp++; if (rd_state !== 2'd2) begin $display("FAIL win_rd_state actual=%0d expected=2", rd_state); n_bad++; end
    n_cmp++; if (all_linked !== 1'b0) begin $display("FAIL win_all_linked actual=%b expected=0", all_linked); n_bad++; end
  endtask

  task automatic test_wrap_and_reset;
    sel_ch = 2'd3;
    link_ch(3, 8'd250);
    n_cmp++; if (linked[3] !== 1'b1) begin $display("FAIL wrap_linked actual=%b expected=1", linked[3]); n_bad++; end
    idle(1);
    n_cmp++; if (all_linked !== 1'b1) begin $display("FAIL wrap_all_linked actual=%b expected=1", all_linked); n_bad++; end
    n_cmp++; if (rd_err_cnt !== 16'd0) begin $display("FAIL wrap_err_cnt actual=%0d expected=0", rd_err_cnt); n_bad++; end
    send1(3, HDR_OK, 8'd10);
    n_cmp++; if (data_valid[3] !== 1'b1) begin $display("FAIL wrap_fwd actual=%b expected=1", data_valid[3]); n_bad++; end
    // Reset in the middle of a cycle with a frame in flight.
    frame_in[3*DATA_W +: DATA_W] = mkf(HDR_OK, 8'd11);
    frame_valid = 4'b1000;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (linked !== 4'b0000) begin $display("FAIL arst_linked actual=%b expected=0000", linked); n_bad++; end
    n_cmp++; if (all_linked !== 1'b0) begin $display("FAIL arst_all_linked actual=%b expected=0", all_linked); n_bad++; end
    n_cmp++; if (err_sticky !== 1'b0) begin $display("FAIL arst_sticky actual=%b expected=0", err_sticky); n_bad++; end
    n_cmp++; if (data_valid !== 4'b0000) begin $display("FAIL arst_data_valid actual=%b expected=0000", data_valid); n_bad++; end
    n_cmp++; if (data_out !== 120'd0) begin $display("FAIL arst_data_out actual=%h expected=0", data_out); n_bad++; end
    n_cmp++; if (rd_state !== 2'd0) begin $display("FAIL arst_rd_state actual=%0d expected=0", rd_state); n_bad++; end
    frame_valid = 4'b0000;
    repeat (2) @(posedge clk160);
    #1 reset = 1'b0;
    idle(1);
    // Channel 0: a slip while in SYNC sends it back to HUNT without counting an error.
    sel_ch = 2'd0;
    for (int i = 0; i < 5; i++) send1(0, HDR_OK, 8'(i));
    send1(0, HDR_OK, 8'd9);
    n_cmp++; if (linked[0] !== 1'b0) begin $display("FAIL resync_slip_linked actual=%b expected=0", linked[0]); n_bad++; end
    n_cmp++; if (err_sticky !== 1'b0) begin $display("FAIL resync_slip_sticky actual=%b expected=0", err_sticky); n_bad++; end
    idle(1);
    n_cmp++; if (rd_state !== 2'd0) begin $display("FAIL resync_slip_state actual=%0d expected=0", rd_state); n_bad++; end
    n_cmp++; if (rd_err_cnt !== 16'd0) begin $display("FAIL resync_slip_err actual=%0d expected=0", rd_err_cnt); n_bad++; end
    link_ch(0, 8'd10);
    n_cmp++; if (linked !== 4'b0001) begin $display("FAIL resync_ch0 actual=%b expected=0001", linked); n_bad++; end
    link_ch(1, 8'd100);
    link_ch(2, 8'd200);
    idle(1);
    n_cmp++; if (linked !== 4'b0111) begin $display("FAIL resync_ch012 actual=%b expected=0111", linked); n_bad++; end
    n_cmp++; if (all_linked !== 1'b0) begin $display("FAIL resync_all_early actual=%b expected=0", all_linked); n_bad++; end
    link_ch(3, 8'd245);
    n_cmp++; if (linked !== 4'b1111) begin $display("FAIL resync_all4 actual=%b expected=1111", linked); n_bad++; end
    n_cmp++; if (all_linked !== 1'b0) begin $display("FAIL resync_all_lag actual=%b expected=0", all_linked); n_bad++; end
    idle(1);
    n_cmp++; if (all_linked !== 1'b1) begin $display("FAIL resync_all_linked actual=%b expected=1", all_linked); n_bad++; end
  endtask

  initial begin
    reset       = 1'b1;
    frame_in    = 120'd0;
    frame_valid = 4'b0000;
    clear_err   = 1'b0;
    sel_ch      = 2'd0;
    repeat (2) @(posedge clk160);
    #1;
    test_reset;
    reset = 1'b0;
    idle(2);
    test_sync;
    test_slip;
    test_clear_err;
    test_loss;
    test_window;
    test_wrap_and_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tds_link_checker_mc.md
Name: tds_link_checker_mc

Overview:
- Parametrised, multi-channel successor to the single strip/pad TDS checker.
- Takes NUM_CH deserialised TDS frame streams in the clk160 domain, already crossed from the GTP user clock.
- Per channel: runs a hunt/sync/linked state machine against a header plus incrementing test-counter pattern; counts sync progress and errors; declares loss of link on error bursts; forwards only good frames.
- A channel-select readout port presents one channel's status to a VIO/ILA for bench debug.

Parameters:
- NUM_CH, 4, number of independent TDS channels.
- DATA_W, 30, frame width per channel.
- HDR_W, 6, header field width in frame bits [DATA_W-1 : DATA_W-HDR_W].
- HEADER, 6'b101010, required header value.
- CNT_W, 8, test counter width in frame bits [CNT_W-1:0].
- SYNC_N, 16, consecutive good frames needed to declare link; max 1023.
- LOSS_N, 4, errors within one window that drop the link.
- WIN, 64, window length in valid frames.
- ERR_W, 16, per-channel error counter width.

Ports:
- clk160, in, 1, system clock, 160 MHz.
- reset, in, 1, asynchronous, active-high reset.
- frame_in, in, NUM_CH*DATA_W, channel c at bits [c*DATA_W +: DATA_W].
- frame_valid, in, NUM_CH, per-channel frame strobe.
- clear_err, in, 1, synchronous clear of all err_cnt values and the sticky error flag.
- sel_ch, in, $clog2(NUM_CH), readout channel select.
- linked, out, NUM_CH, per-channel link status.
- all_linked, out, 1, AND of linked.
- err_sticky, out, 1, set by any error on a linked channel; cleared by clear_err.
- data_out, out, NUM_CH*DATA_W, forwarded good frames.
- data_valid, out, NUM_CH, forwarded-frame strobe.
- rd_state, out, 2, FSM state of channel sel_ch.
- rd_syn_cnt, out, 10, sync count of channel sel_ch.
- rd_err_cnt, out, ERR_W, error count of channel sel_ch.

Behaviour:
- Reset (async assert, sync release via clk160): all FSMs go to HUNT. All counters, linked, all_linked, err_sticky, data_out and data_valid reset to 0.
- Frame evaluation happens only on a cycle where frame_valid[c] = 1. Invalid cycles leave all channel-c state unchanged.
- hdr_ok: header field == HEADER.
- cnt_ok: counter field == exp[c], where exp[c] is CNT_W bits and wraps 255 -> 0.
- After every valid frame, exp[c] = received counter + 1. A single slip therefore costs exactly one error.
- FSM state encoding: HUNT = 0, SYNC = 1, LINKED = 2; 3 is unused and recovers to HUNT.
- HUNT: on hdr_ok -> SYNC with syn_cnt = 1. Otherwise stay, syn_cnt = 0.
- SYNC: hdr_ok && cnt_ok -> syn_cnt++. When syn_cnt reaches SYNC_N -> LINKED, linked[c] = 1 on that same registered edge. Any bad frame -> HUNT, syn_cnt = 0.
- LINKED, bad frame:
  - err_cnt[c]++, saturating at all-ones.
  - err_sticky = 1.
  - win_err[c]++.
  - If win_err reaches LOSS_N -> HUNT: linked[c] = 0, syn_cnt = 0, win_err = 0. err_cnt is retained.
- LINKED, window: win_frm[c] counts valid frames. When it wraps at WIN, win_err is zeroed on that same frame. If that frame is also bad, win_err = 1.
- Forwarding: data_valid[c] = 1 exactly 1 cycle after a valid frame that is good while in LINKED. data_out holds the frame from that cycle; otherwise data_out holds its last value.
- clear_err coinciding with an error: clear wins, but that error still counts. Result is err_cnt = 1 and err_sticky = 1.
- Errors in HUNT or SYNC do not touch err_cnt or err_sticky.
- all_linked and the rd_* outputs are registered, 1 cycle after the per-channel registers. An out-of-range sel_ch reads as all zeros.
- Channels are fully independent; simultaneous events on different channels have no interaction.

Decomposition:
- Package tds_chk_pkg holds:
  - state typedef (HUNT/SYNC/LINKED);
  - syn_cnt width constant (10);
  - default HEADER constant.
- One sub-module, tds_link_chan: a single-channel FSM plus counters and the forward register, instantiated NUM_CH times by generate.
- The top level holds all_linked, err_sticky OR-reduction, and the readout mux.

Test Plan:
1. Channel 0 sends 16 valid frames: header 101010, counter 0..15. -> linked[0] rises 1 cycle after the 16th frame. rd_syn_cnt (sel_ch = 0) reads 16, rd_state reads 2. The first data_valid[0] appears for the 17th frame.
2. Linked channel receives counter 20, 21, 25, 26. -> exactly 1 error on the 25 frame; err_cnt = 1, err_sticky = 1. The 26 frame is forwarded, and the link stays up.
3. Linked channel receives 4 bad-header frames within 64 frames. -> linked drops after the 4th, state = HUNT, err_cnt = 4. Resync then requires 16 new good frames.
4. 3 errors, then 64 clean frames, then 3 more errors. -> linked stays 1 and err_cnt = 6.
5. clear_err pulsed in the same cycle as an error frame. -> err_cnt = 1, err_sticky = 1. A clear_err alone afterwards gives 0 and 0.
6. All 4 channels linked; reset asserted mid-stream for 2 cycles. -> all outputs 0 immediately (asynchronously). After release, each channel resyncs independently; all_linked rises only after the last channel links. Counter wrap 255 -> 0 is accepted with no error.
